// File: rtl/rf16x81_queue_ctl_pkg.sv
// Shared constants and types for the rf16x81 queue controller.
// The queue sits on a 16x81 register-file macro and uses a 3-entry output buffer.
package rf16x81_queue_ctl_pkg;

    localparam int DEPTH      = 16;
    localparam int WIDTH      = 81;
    localparam int OBUF_DEPTH = 3;
    localparam int PTR_W      = 4;
    localparam int CNT_W      = 5;
    localparam int OB_CNT_W   = 2;

    localparam logic [4:0] MARGIN_DFLT = 5'b10101;

    typedef logic [WIDTH-1:0] data_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/rf16x81_obuf.sv
// 3-entry, 81-bit FIFO for the array's read returns.
// It is a shift register, so the head (data) is always entry 0, straight from a flop.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   capture    : write cap_data at the tail this cycle
//   cap_data   : data to capture
//   pop        : drop the head this cycle (only asserted while vld)
//   vld        : registered, buffer not empty
//   data       : head entry
//   cnt        : number of entries held (0..3)
module rf16x81_obuf
    import rf16x81_queue_ctl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                capture,
    input  data_t               cap_data,
    input  logic                pop,
    output logic                vld,
    output data_t               data,
    output logic [OB_CNT_W-1:0] cnt
);

    data_t               mem_q [OBUF_DEPTH];
    data_t               mem_d [OBUF_DEPTH];
    logic [OB_CNT_W-1:0] cnt_q;
    logic [OB_CNT_W-1:0] cnt_d;
    logic [OB_CNT_W-1:0] fill_idx;
    logic                vld_q;
    logic                vld_d;

    always_comb begin
        mem_d    = mem_q;
        fill_idx = cnt_q - OB_CNT_W'(pop);
        if (pop) begin
            for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
        end
        // Capture lands after the shift, so a simultaneous pop and capture
        // put the new word in the slot the pop just freed.
        if (capture) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                if (OB_CNT_W'(i) == fill_idx) begin
                    mem_d[i] = cap_data;
                end
            end
        end
        cnt_d = fill_idx + OB_CNT_W'(capture);
        vld_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign vld  = vld_q;
    assign data = mem_q[0];
    assign cnt  = cnt_q;

endmodule

// File: rtl/rf16x81_queue_ctl.sv
// 16-deep, 81-bit queue controller driving both ports of an external 16x81
// register-file macro. Writes go straight to the array; reads are issued as soon
// as an entry is readable and the output buffer has room, and the one-cycle read
// latency is absorbed by a 3-entry output buffer feeding the pop interface.
// Ports:
//   rclk, reset              : clock, synchronous active-high reset
//   push_vld/push_data/push_rdy : producer interface (push_rdy registered)
//   pop_vld/pop_data/pop_rdy    : consumer interface (pop_vld/pop_data registered)
//   count                    : entries held in array + in flight + output buffer
//   rf_csn_wr/rf_wr_a/rf_di  : array write port (active-low select)
//   rf_csn_rd/rf_rd_a/rf_do  : array read port, rf_do valid one cycle after issue
//   rf_hold/rf_testmux_sel/rf_margin : array static controls
module rf16x81_queue_ctl
    import rf16x81_queue_ctl_pkg::*;
(
    input  logic       rclk,
    input  logic       reset,
    input  logic       push_vld,
    input  data_t      push_data,
    output logic       push_rdy,
    output logic       pop_vld,
    output data_t      pop_data,
    input  logic       pop_rdy,
    output cnt_t       count,
    output logic       rf_csn_wr,
    output ptr_t       rf_wr_a,
    output data_t      rf_di,
    output logic       rf_csn_rd,
    output ptr_t       rf_rd_a,
    input  data_t      rf_do,
    output logic       rf_hold,
    output logic       rf_testmux_sel,
    output logic [4:0] rf_margin
);

    ptr_t                wr_ptr_q, wr_ptr_d;
    ptr_t                rd_ptr_q, rd_ptr_d;
    cnt_t                arr_cnt_q, arr_cnt_d;
    cnt_t                count_q, count_d;
    logic                inflight_q, inflight_d;
    logic                push_rdy_q, push_rdy_d;
    logic                push_acc;
    logic                issue;
    logic                pop;
    logic [OB_CNT_W-1:0] ob_cnt;

    // arr_cnt_q only reflects pushes from earlier cycles, so it is also the
    // readable-entry count: a push in this cycle can never be read on the same
    // edge it is written.
    always_comb begin
        push_acc   = push_vld & push_rdy_q;
        pop        = pop_vld & pop_rdy;
        issue      = (arr_cnt_q != '0) &&
                     ((3'(ob_cnt) + 3'(inflight_q)) < 3'(OBUF_DEPTH));

        wr_ptr_d   = wr_ptr_q + PTR_W'(push_acc);
        rd_ptr_d   = rd_ptr_q + PTR_W'(issue);
        arr_cnt_d  = arr_cnt_q + CNT_W'(push_acc) - CNT_W'(issue);
        count_d    = count_q + CNT_W'(push_acc) - CNT_W'(pop);
        inflight_d = issue;
        push_rdy_d = (arr_cnt_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            arr_cnt_q  <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            push_rdy_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            arr_cnt_q  <= arr_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            push_rdy_q <= push_rdy_d;
        end
    end

    // inflight_q is cleared by reset, so a read return arriving the cycle
    // after reset is never captured.
    rf16x81_obuf u_obuf (
        .clk      (rclk),
        .reset    (reset),
        .capture  (inflight_q),
        .cap_data (rf_do),
        .pop      (pop),
        .vld      (pop_vld),
        .data     (pop_data),
        .cnt      (ob_cnt)
    );

    assign push_rdy       = push_rdy_q;
    assign count          = count_q;
    assign rf_csn_wr      = ~push_acc;
    assign rf_wr_a        = wr_ptr_q;
    assign rf_di          = push_data;
    assign rf_csn_rd      = ~issue;
    assign rf_rd_a        = rd_ptr_q;
    assign rf_hold        = 1'b0;
    assign rf_testmux_sel = 1'b0;
    assign rf_margin      = MARGIN_DFLT;

endmodule

// File: tb/tb_rf16x81_queue_ctl.sv
module tb_rf16x81_queue_ctl;

    logic        rclk = 1'b0;
    logic        reset = 1'b1;
    logic        push_vld = 1'b0;
    logic [80:0] push_data = '0;
    logic        push_rdy;
    logic        pop_vld;
    logic [80:0] pop_data;
    logic        pop_rdy = 1'b0;
    logic [4:0]  count;
    logic        rf_csn_wr;
    logic [3:0]  rf_wr_a;
    logic [80:0] rf_di;
    logic        rf_csn_rd;
    logic [3:0]  rf_rd_a;
    logic [80:0] rf_do = '1;
    logic        rf_hold;
    logic        rf_testmux_sel;
    logic [4:0]  rf_margin;

    rf16x81_queue_ctl dut (
        .rclk           (rclk),
        .reset          (reset),
        .push_vld       (push_vld),
        .push_data      (push_data),
        .push_rdy       (push_rdy),
        .pop_vld        (pop_vld),
        .pop_data       (pop_data),
        .pop_rdy        (pop_rdy),
        .count          (count),
        .rf_csn_wr      (rf_csn_wr),
        .rf_wr_a        (rf_wr_a),
        .rf_di          (rf_di),
        .rf_csn_rd      (rf_csn_rd),
        .rf_rd_a        (rf_rd_a),
        .rf_do          (rf_do),
        .rf_hold        (rf_hold),
        .rf_testmux_sel (rf_testmux_sel),
        .rf_margin      (rf_margin)
    );

    always #5 rclk = ~rclk;

    // Behavioural register-file macro: write and read ports on rclk,
    // read data one cycle after select, all-ones when not selected.
    logic [80:0] rf_mem [16];
    always @(posedge rclk) begin
        if (!rf_csn_wr) rf_mem[rf_wr_a] <= rf_di;
        if (!rf_csn_rd) rf_do <= rf_mem[rf_rd_a];
        else            rf_do <= '1;
    end

    // Reference model: FIFO of accepted words with their push cycle, plus
    // ordinal counts of writes and read issues since reset.
    typedef struct {
        logic [80:0] data;
        int          cyc;
    } entry_t;

    entry_t q[$];
    int     n_wr;
    int     n_rd;
    int     cyc;
    int     total = 0;
    int     bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [80:0] rnd81();
        return 81'({$urandom, $urandom, $urandom});
    endfunction

    // One cycle: drive inputs at the negedge, check outputs 1 time unit later,
    // then update the model with the handshakes that the coming edge commits.
    task automatic step(input logic pv, input logic [80:0] pd, input logic pr);
        logic acc;
        logic pp;
        @(negedge rclk);
        push_vld  = pv;
        push_data = pd;
        pop_rdy   = pr;
        #1;
        acc = pv & push_rdy;
        pp  = pop_vld & pr;

        chk("count", 128'(count), 128'(q.size()));
        if (q.size() < 16) chk("push_rdy_free", 128'(push_rdy), 128'(1));
        if (!push_rdy)     chk("push_rdy_full", 128'(q.size() >= 16), 128'(1));
        if (pop_vld)       chk("pop_vld_empty", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0 && (cyc - q[0].cyc) >= 4)
            chk("pop_vld_late", 128'(pop_vld), 128'(1));

        chk("csn_wr", 128'(rf_csn_wr), 128'(!acc));
        if (acc) begin
            chk("wr_a", 128'(rf_wr_a), 128'(n_wr % 16));
            chk("rf_di", 128'(rf_di), 128'(pd));
        end
        if (!rf_csn_rd) begin
            chk("rd_a", 128'(rf_rd_a), 128'(n_rd % 16));
            chk("rd_before_wr", 128'(n_rd < n_wr), 128'(1));
            if (!rf_csn_wr) chk("rd_wr_same_a", 128'(rf_rd_a != rf_wr_a), 128'(1));
            n_rd++;
        end
        if (rf_margin != 5'b10101 || rf_hold !== 1'b0 || rf_testmux_sel !== 1'b0)
            chk("rf_static", 128'({rf_margin, rf_hold, rf_testmux_sel}), 128'({5'b10101, 2'b00}));

        if (pp && q.size() != 0) begin
            chk("pop_data", 128'(pop_data), 128'(q[0].data));
            void'(q.pop_front());
        end
        if (acc) begin
            q.push_back('{data: pd, cyc: cyc});
            n_wr++;
        end
        cyc++;
    endtask

    // Reset held for two cycles with push_vld high; checks outputs after the first.
    task automatic do_reset();
        @(negedge rclk);
        reset    = 1'b1;
        push_vld = 1'b1;
        pop_rdy  = 1'b0;
        @(negedge rclk);
        #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_pop_vld", 128'(pop_vld), 128'(0));
        chk("rst_push_rdy", 128'(push_rdy), 128'(0));
        chk("rst_csn_wr", 128'(rf_csn_wr), 128'(1));
        chk("rst_csn_rd", 128'(rf_csn_rd), 128'(1));
        @(negedge rclk);
        reset    = 1'b0;
        push_vld = 1'b0;
        q.delete();
        n_wr = 0;
        n_rd = 0;
    endtask

    typedef struct {
        logic        pv;
        logic [80:0] pd;
        logic        pr;
        logic        e_prdy;
        logic        e_vld;
        logic [4:0]  e_cnt;
        logic        e_csn_wr;
        logic        e_csn_rd;
        logic [3:0]  e_wr_a;
        logic [3:0]  e_rd_a;
        logic [80:0] e_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [80:0] a;
        logic [80:0] b;
        logic [80:0] d;
        int          acc_cnt;
        n_wr = 0;
        n_rd = 0;
        cyc  = 0;
        a = 81'h1_2345_6789_ABCD_EF01_2345;
        b = 81'h0_DEAD_BEEF_0000_1111_2222;

        //          pv  pd  pr  prdy vld cnt csnwr csnrd wr_a rd_a data
        vecs[0] = '{1'b1, a,  1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 4'd0, 4'd0, '0};
        vecs[1] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 4'd0, 4'd0, '0};
        vecs[2] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 4'd0, 4'd0, '0};
        vecs[3] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 4'd0, 4'd0, a};
        vecs[4] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 4'd0, 4'd0, a};
        vecs[5] = '{1'b1, b,  1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 4'd1, 4'd0, '0};
        vecs[6] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 4'd0, 4'd1, '0};
        vecs[7] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 4'd0, 4'd0, '0};
        vecs[8] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 4'd0, 4'd0, b};
        vecs[9] = '{1'b0, '0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 4'd0, 4'd0, '0};

        // Single-push latency and addressing.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].pv, vecs[i].pd, vecs[i].pr);
            chk($sformatf("vec%0d_push_rdy", i), 128'(push_rdy), 128'(vecs[i].e_prdy));
            chk($sformatf("vec%0d_pop_vld", i), 128'(pop_vld), 128'(vecs[i].e_vld));
            chk($sformatf("vec%0d_count", i), 128'(count), 128'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_csn_wr", i), 128'(rf_csn_wr), 128'(vecs[i].e_csn_wr));
            chk($sformatf("vec%0d_csn_rd", i), 128'(rf_csn_rd), 128'(vecs[i].e_csn_rd));
            if (!vecs[i].e_csn_wr) chk($sformatf("vec%0d_wr_a", i), 128'(rf_wr_a), 128'(vecs[i].e_wr_a));
            if (!vecs[i].e_csn_rd) chk($sformatf("vec%0d_rd_a", i), 128'(rf_rd_a), 128'(vecs[i].e_rd_a));
            if (vecs[i].e_vld) chk($sformatf("vec%0d_pop_data", i), 128'(pop_data), 128'(vecs[i].e_data));
        end

        // Count = 1: push + pop leaves count at 1.
        step(1'b1, 81'h55, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 81'h66, 1'b1);
        chk("cnt1_pop_vld", 128'(pop_vld), 128'(1));
        step(1'b0, '0, 1'b0);
        chk("cnt1_count", 128'(count), 128'(1));
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        chk("cnt1_drained", 128'(count), 128'(0));

        // Fill to capacity with pop_rdy low.
        do_reset();
        acc_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 81'(i + 100), 1'b0);
            if (!push_rdy) break;
            acc_cnt++;
        end
        chk("full_accepted", 128'(acc_cnt), 128'(19));
        chk("full_count", 128'(count), 128'(19));
        chk("full_push_rdy", 128'(push_rdy), 128'(0));
        // Push + pop at 19: push refused, count drops to 18.
        step(1'b1, 81'h7777, 1'b1);
        chk("full_pp_push_rdy", 128'(push_rdy), 128'(0));
        step(1'b0, '0, 1'b0);
        chk("full_pp_count", 128'(count), 128'(18));
        for (int i = 0; i < 60 && q.size() != 0; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("full_drain_count", 128'(count), 128'(0));
        chk("full_drain_vld", 128'(pop_vld), 128'(0));

        // Continuous push and pop.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 81'(i + 1000), 1'b1);
            chk("stream_count", 128'(count), 128'(i < 3 ? i : 3));
            if (i >= 3) chk("stream_pop_vld", 128'(pop_vld), 128'(1));
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        chk("stream_drained", 128'(count), 128'(0));

        // Reset with a read in flight and five entries held.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 81'(i + 500), 1'b0);
        step(1'b1, 81'h505, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("midrst_count_before", 128'(count), 128'(5));
        do_reset();
        d = 81'h1_F0F0_F0F0_F0F0_F0F0_F0F0;
        step(1'b1, d, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        chk("midrst_new_vld", 128'(pop_vld), 128'(1));
        chk("midrst_new_data", 128'(pop_data), 128'(d));
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("midrst_empty", 128'(pop_vld), 128'(0));

        // Random traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            int mode;
            mode = (i / 1000) % 4;
            step(($urandom_range(0, 9) < (mode == 1 ? 9 : 5)) ? 1'b1 : 1'b0, rnd81(),
                 ($urandom_range(0, 9) < (mode == 2 ? 9 : (mode == 3 ? 2 : 6))) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 60 && q.size() != 0; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("rand_drained", 128'(count), 128'(0));
        chk("rand_model_empty", 128'(q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
